seq_adder_16: RTL

SEQ_ADDER_16 -- requirements
Module: seq_adder_16

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_4bit.sv | 13 +
 rtl/seq_adder_16.sv | 111 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding and slice geometry.
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the slice index; one bit minimum so a single-slice build still has a legal vector.
    function automatic int idx_w(input int width);
        return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
    endfunction

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple slice: {Cout, Sum} = A + B + C.
module adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C,
    output logic [3:0] Sum,
    output logic       Cout
);

    // Plain 5-bit add; the top bit is the slice carry-out.
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0, C};

endmodule

// File: rtl/seq_adder_16.sv
// Slice-serial add/subtract: one 4-bit slice per cycle through a single adder_4bit,
// valid/ready on both sides, result held in DONE until the consumer takes it.
module seq_adder_16
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int IW  = idx_w(WIDTH);

    state_e             state, state_nx;
    logic [WIDTH-1:0]   a_r, b_r, sum_r;
    logic               carry_r, sub_r;
    logic [IW-1:0]      idx;
    logic               last;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic               sl_cin, sl_cout;

    // Operand slices selected by the running index.
    assign sl_a   = a_r[idx*SLICE_W +: SLICE_W];
    assign sl_b   = b_r[idx*SLICE_W +: SLICE_W];
    // The first slice takes the subtract carry-in straight from the latched mode;
    // later slices ripple through carry_r.
    assign sl_cin = (idx == '0) ? sub_r : carry_r;
    assign last   = (idx == IW'(NSL - 1));

    adder_4bit u_slice (
        .A    (sl_a),
        .B    (sl_b),
        .C    (sl_cin),
        .Sum  (sl_sum),
        .Cout (sl_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and per-slice accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r     <= a;
                    b_r     <= sub ? ~b : b;
                    carry_r <= sub;
                    sub_r   <= sub;
                    idx     <= '0;
                end
                RUN: begin
                    sum_r[idx*SLICE_W +: SLICE_W] <= sl_sum;
                    carry_r                       <= sl_cout;
                    idx                           <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = carry_r;
    assign ovf  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_r[WIDTH-1] != a_r[WIDTH-1]);
    assign zero = (sum_r == '0);

endmodule
